fetch_unit: RTL and testbench

- Instruction-fetch stage of the 8-bit processor, directly upstream of instruction_memory.
- Owns the program counter and drives the instruction memory's 8-bit read address.
- Captures the combinational 8-bit instruction into a one-entry output register and hands it to decode with a valid/ready handshake.
- Handles branch/jump redirect (with flush), stall via backpressure, and an out-of-range address fault.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_program_counter.sv | 42 ++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and fetch FSM encoding for the 8-bit
// processor front end.
//   ADDR_W      - instruction address width
//   INSTR_W     - instruction width
//   HALT_OPCODE - opcode that stops fetching when halt detection is built in
//   fetch_state_t - fetch_unit state encoding
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: valid/ready hand-off from the fetch stage to decode.
//   instr_valid - output register holds an instruction
//   instr_ready - decode accepts the instruction this cycle
//   instr_out   - captured instruction
//   instr_pc    - address instr_out was fetched from
// Modports: master = fetch side (producer), slave = decode side (consumer).
interface fetch_unit_if;
  import cpu_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output instr_valid,
    output instr_out,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit_program_counter.sv
// program_counter: the fetch-stage PC register.
//   clk, rst_n - clock, asynchronous active-low reset (pc <= RESET_PC)
//   load       - redirect: pc <= target (wins over inc)
//   target     - redirect destination
//   inc        - an instruction was captured: pc <= pc + 1 (wraps at 256)
//   pc         - current program counter
module program_counter
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    if (load) begin
      pc_next = target;
    end else if (inc) begin
      pc_next = pc_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, addresses the
// instruction memory, captures the returned instruction into a one-entry
// output register and hands it to decode over fetch_unit_if.
//   clk, rst_n       - clock, asynchronous active-low reset
//   fetch_enable     - level, permits fetching
//   read_address     - current PC to instruction_memory
//   instruction      - same-cycle instruction from instruction_memory
//   redirect_valid   - taken branch/jump pulse from execute (flushes)
//   redirect_target  - new PC for the redirect
//   halted           - (FETCH_HALT_DETECT_EN only) HALT opcode was fetched
//   dec              - valid/ready instruction output to decode
//   fault            - sticky: PC left the legal 0..MEM_DEPTH-1 range
// Build option: define FETCH_HALT_DETECT_EN to stop fetching after the
// HALT opcode is captured.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter int                MEM_DEPTH = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_enable,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
`ifdef FETCH_HALT_DETECT_EN
  output logic               halted,
`endif
  fetch_unit_if.master       dec,
  output logic               fault
);

  // One extra bit so MEM_DEPTH=256 (every address legal) is representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  fetch_state_t state_reg, state_next;

  logic               valid_reg, valid_next;
  logic [INSTR_W-1:0] out_reg, out_next;
  logic [ADDR_W-1:0]  ipc_reg, ipc_next;

  logic [ADDR_W-1:0]  pc;
  logic               pc_load;
  logic               pc_inc;
  logic               slot_free;
  logic               pc_in_range;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pc_load),
    .target (redirect_target),
    .inc    (pc_inc),
    .pc     (pc)
  );

  assign slot_free   = !valid_reg || dec.instr_ready;
  assign pc_in_range = {1'b0, pc} < DEPTH_LIM;

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    out_next   = out_reg;
    ipc_next   = ipc_reg;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (redirect_valid) begin
          pc_load    = 1'b1;
          valid_next = 1'b0;
        end else if (fetch_enable) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (redirect_valid) begin
          // Flush; a same-cycle transfer has already been taken by decode.
          pc_load    = 1'b1;
          valid_next = 1'b0;
        end else if (!pc_in_range) begin
          state_next = FAULT;
          if (dec.instr_ready) valid_next = 1'b0;
        end else if (fetch_enable && slot_free) begin
          valid_next = 1'b1;
          out_next   = instruction;
          ipc_next   = pc;
`ifdef FETCH_HALT_DETECT_EN
          if (instruction == HALT_OPCODE) begin
            // HALT is delivered, but pc stays parked on it.
            state_next = HALT;
          end else begin
            pc_inc = 1'b1;
          end
`else
          pc_inc = 1'b1;
`endif
        end else if (dec.instr_ready) begin
          valid_next = 1'b0;
        end
      end

      FAULT: begin
        valid_next = 1'b0;
      end

      HALT: begin
        // Let the HALT instruction drain to decode; nothing else happens.
        if (dec.instr_ready) valid_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      out_reg   <= '0;
      ipc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      out_reg   <= out_next;
      ipc_reg   <= ipc_next;
    end
  end

  assign read_address    = pc;
  assign dec.instr_valid = valid_reg;
  assign dec.instr_out   = out_reg;
  assign dec.instr_pc    = ipc_reg;
  assign fault           = (state_reg == FAULT);
`ifdef FETCH_HALT_DETECT_EN
  assign halted          = (state_reg == HALT);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a scoreboard. The
// stimulus pushes expected (instruction, pc) pairs; a negedge monitor pops
// one entry per accepted transfer and compares.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               fetch_enable;
  logic [ADDR_W-1:0]  read_address;
  logic [INSTR_W-1:0] instruction;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               fault;
`ifdef FETCH_HALT_DETECT_EN
  logic               halted;
`endif

  fetch_unit_if dec_if ();

  fetch_unit #(
    .RESET_PC  (8'h00),
    .MEM_DEPTH (25)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_enable    (fetch_enable),
    .read_address    (read_address),
    .instruction     (instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
`ifdef FETCH_HALT_DETECT_EN
    .halted          (halted),
`endif
    .dec             (dec_if.master),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: combinational read.
  logic [7:0] mem [256];
  assign instruction = mem[read_address];

  typedef struct packed {
    logic [7:0] ins;
    logic [7:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_pc  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Hand-computed memory image: 0..3 are 11,22,33,44; others are A0^addr.
  function automatic logic [7:0] exp_instr(input int a);
    case (a)
      0:  return 8'h11;
      1:  return 8'h22;
      2:  return 8'h33;
      3:  return 8'h44;
      4:  return 8'hA4;
      5:  return 8'hA5;
      16: return 8'hB0;
      default: return 8'hA0 ^ 8'(a);
    endcase
  endfunction

  task automatic push(input int a);
    exp_t e;
    e.ins = exp_instr(a);
    e.pc  = 8'(a);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one line per accepted transfer, compared against the queue.
  always @(negedge clk) begin
    if (rst_n && dec_if.instr_valid && dec_if.instr_ready) begin
      $display("xfer pc=0x%02h instr=0x%02h", dec_if.instr_pc, dec_if.instr_out);
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_pc", {24'h0, dec_if.instr_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_instr", {24'h0, dec_if.instr_out}, {24'h0, e.ins});
        chk("xfer_pc",    {24'h0, dec_if.instr_pc},  {24'h0, e.pc});
      end
      last_pc = int'(dec_if.instr_pc);
    end
  end

  initial begin
    bit hit;
    for (int i = 0; i < 256; i++) mem[i] = 8'hA0 ^ 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    rst_n              = 1'b1;
    fetch_enable       = 1'b0;
    dec_if.instr_ready = 1'b0;
    redirect_valid     = 1'b0;
    redirect_target    = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'h0, dec_if.instr_valid}, 32'h0);
    chk("rst_out",   {24'h0, dec_if.instr_out},   32'h0);
    chk("rst_ipc",   {24'h0, dec_if.instr_pc},    32'h0);
    chk("rst_fault", {31'h0, fault},              32'h0);
    chk("rst_pc",    {24'h0, read_address},       32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Sequential fetch with a 3-cycle stall on 8'h22.
    for (int a = 0; a <= 5; a++) push(a);
    fetch_enable       = 1'b1;
    dec_if.instr_ready = 1'b1;
    step();
    chk("first_cycle_valid", {31'h0, dec_if.instr_valid}, 32'h0);
    step();
    chk("first_valid",     {31'h0, dec_if.instr_valid}, 32'h1);
    chk("first_instr",     {24'h0, dec_if.instr_out},   32'h11);
    step();
    dec_if.instr_ready = 1'b0;
    chk("seq_instr1", {24'h0, dec_if.instr_out}, 32'h22);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_instr", {24'h0, dec_if.instr_out},   32'h22);
      chk("stall_ipc",   {24'h0, dec_if.instr_pc},    32'h01);
      chk("stall_pc",    {24'h0, read_address},       32'h02);
      chk("stall_valid", {31'h0, dec_if.instr_valid}, 32'h1);
    end
    dec_if.instr_ready = 1'b1;
    step();
    chk("post_stall_instr", {24'h0, dec_if.instr_out}, 32'h33);

    // Redirect to 0x10 while pc 5 is being delivered.
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (dec_if.instr_valid && dec_if.instr_pc == 8'h05) hit = 1;
      else step();
    end
    chk("wait_pc5", {31'h0, hit}, 32'h1);
    redirect_valid  = 1'b1;
    redirect_target = 8'h10;
    step();
    redirect_valid = 1'b0;
    chk("redir_flush", {31'h0, dec_if.instr_valid}, 32'h0);
    chk("redir_pc",    {24'h0, read_address},       32'h10);
    for (int a = 16; a <= 24; a++) push(a);
    step();
    chk("redir_valid", {31'h0, dec_if.instr_valid}, 32'h1);
    chk("redir_instr", {24'h0, dec_if.instr_out},   32'hB0);
    chk("redir_ipc",   {24'h0, dec_if.instr_pc},    32'h10);

    // Run off the end of memory into FAULT.
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step();
      if (fault) hit = 1;
    end
    chk("fault_reached", {31'h0, hit},              32'h1);
    chk("fault_valid",   {31'h0, dec_if.instr_valid}, 32'h0);
    chk("fault_last_pc", 32'(last_pc),              32'd24);
    redirect_valid  = 1'b1;
    redirect_target = 8'h00;
    step();
    redirect_valid = 1'b0;
    step();
    chk("fault_sticky",    {31'h0, fault},              32'h1);
    chk("fault_ign_redir", {24'h0, read_address},       32'h19);
    chk("fault_no_valid",  {31'h0, dec_if.instr_valid}, 32'h0);
    chk("queue_after_fault", 32'(exp_q.size()),         32'h0);

    // Asynchronous reset in the middle of a stall.
    fetch_enable = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("fault_cleared", {31'h0, fault}, 32'h0);
    dec_if.instr_ready = 1'b0;
    fetch_enable       = 1'b1;
    step(); step(); step();
    chk("pre_areset_valid", {31'h0, dec_if.instr_valid}, 32'h1);
    chk("pre_areset_pc",    {24'h0, read_address},       32'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", {31'h0, dec_if.instr_valid}, 32'h0);
    chk("areset_pc",    {24'h0, read_address},       32'h00);
    chk("areset_out",   {24'h0, dec_if.instr_out},   32'h00);
    step();
    rst_n = 1'b1;

`ifdef FETCH_HALT_DETECT_EN
    // HALT opcode at address 2: delivered, then fetching stops.
    fetch_enable = 1'b0;
    step();
    mem[2] = 8'hFF;
    push(0); push(1);
    begin
      exp_t e;
      e.ins = 8'hFF;
      e.pc  = 8'h02;
      exp_q.push_back(e);
    end
    fetch_enable       = 1'b1;
    dec_if.instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("halt_halted", {31'h0, halted},              32'h1);
    chk("halt_pc",     {24'h0, read_address},        32'h02);
    chk("halt_valid",  {31'h0, dec_if.instr_valid},  32'h0);
    chk("halt_last",   32'(last_pc),                 32'd2);
    redirect_valid  = 1'b1;
    redirect_target = 8'h08;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("halt_ign_redir", {24'h0, read_address}, 32'h02);
    chk("halt_sticky",    {31'h0, halted},       32'h1);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound in case the stimulus ever stops advancing.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
